// File: rtl/rf_write_arbiter_if.sv
// Write-request and write-port bundle for rf_write_arbiter.
// master = requester/register-file side, slave = the arbiter.
interface rf_write_arbiter_if;

    // Handshake: a request is taken on a rising edge when x_valid && x_ready.
    // x_ready depends only on FIFO occupancy, never on x_valid or a same-cycle pop.
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_reg;
    logic [15:0] alu_data;

    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_reg;
    logic [15:0] mem_data;

    logic        WriteReg;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic [15:0] pending_mask;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        input  alu_ready, mem_ready,
        input  WriteReg, DstReg, DstData, pending_mask
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        output alu_ready, mem_ready,
        output WriteReg, DstReg, DstData, pending_mask
    );

endinterface

// File: rtl/rf_write_arbiter.sv
// Merges ALU and load-return writebacks onto the single register-file write port.
// Define RF_ARB_RR_EN for round-robin arbitration; otherwise MEM has fixed priority.
module rf_write_arbiter #(
    parameter int DEPTH = 2
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // ALU FIFO state
    logic [3:0]       aluRegQ  [DEPTH];
    logic [15:0]      aluDataQ [DEPTH];
    logic [DEPTH-1:0] aluVld;
    logic [PW-1:0]    aluWr;
    logic [PW-1:0]    aluRd;
    logic [CW-1:0]    aluCount;

    // MEM FIFO state
    logic [3:0]       memRegQ  [DEPTH];
    logic [15:0]      memDataQ [DEPTH];
    logic [DEPTH-1:0] memVld;
    logic [PW-1:0]    memWr;
    logic [PW-1:0]    memRd;
    logic [CW-1:0]    memCount;

    logic aluPush, aluPop, aluNotEmpty;
    logic memPush, memPop, memNotEmpty;
    logic grantAlu, grantMem;

    logic        writeReg;
    logic [3:0]  dstReg;
    logic [15:0] dstData;
    logic [15:0] pendingMask;

    assign bus.alu_ready = (aluCount < FULL_COUNT);
    assign bus.mem_ready = (memCount < FULL_COUNT);

    assign aluPush     = bus.alu_valid && bus.alu_ready;
    assign memPush     = bus.mem_valid && bus.mem_ready;
    assign aluNotEmpty = (aluCount != '0);
    assign memNotEmpty = (memCount != '0);
    assign aluPop      = grantAlu;
    assign memPop      = grantMem;

`ifdef RF_ARB_RR_EN
    // Remembers the last winner; reset to MEM so the first contention goes to ALU.
    logic lastGrantMem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastGrantMem <= 1'b1;
        end else if (grantMem) begin
            lastGrantMem <= 1'b1;
        end else if (grantAlu) begin
            lastGrantMem <= 1'b0;
        end
    end

    always_comb begin
        grantMem = memNotEmpty && (!aluNotEmpty || !lastGrantMem);
    end
`else
    always_comb begin
        grantMem = memNotEmpty;
    end
`endif

    always_comb begin
        grantAlu = aluNotEmpty && !grantMem;
    end

    // ALU FIFO pointers, occupancy and per-entry valid bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aluWr    <= '0;
            aluRd    <= '0;
            aluCount <= '0;
            aluVld   <= '0;
        end else begin
            if (aluPush) begin
                aluWr <= aluWr + PW'(1);
            end
            if (aluPop) begin
                aluRd <= aluRd + PW'(1);
            end
            case ({aluPush, aluPop})
                2'b10:   aluCount <= aluCount + CW'(1);
                2'b01:   aluCount <= aluCount - CW'(1);
                default: aluCount <= aluCount;
            endcase
            // Push and pop never target the same slot: push needs a non-full FIFO.
            if (aluPop) begin
                aluVld[aluRd] <= 1'b0;
            end
            if (aluPush) begin
                aluVld[aluWr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aluPush) begin
            aluRegQ[aluWr]  <= bus.alu_reg;
            aluDataQ[aluWr] <= bus.alu_data;
        end
    end

    // MEM FIFO pointers, occupancy and per-entry valid bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memWr    <= '0;
            memRd    <= '0;
            memCount <= '0;
            memVld   <= '0;
        end else begin
            if (memPush) begin
                memWr <= memWr + PW'(1);
            end
            if (memPop) begin
                memRd <= memRd + PW'(1);
            end
            case ({memPush, memPop})
                2'b10:   memCount <= memCount + CW'(1);
                2'b01:   memCount <= memCount - CW'(1);
                default: memCount <= memCount;
            endcase
            if (memPop) begin
                memVld[memRd] <= 1'b0;
            end
            if (memPush) begin
                memVld[memWr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (memPush) begin
            memRegQ[memWr]  <= bus.mem_reg;
            memDataQ[memWr] <= bus.mem_data;
        end
    end

    // Write-port register: address and data hold when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            writeReg <= 1'b0;
            dstReg   <= '0;
            dstData  <= '0;
        end else begin
            writeReg <= grantAlu || grantMem;
            if (grantMem) begin
                dstReg  <= memRegQ[memRd];
                dstData <= memDataQ[memRd];
            end else if (grantAlu) begin
                dstReg  <= aluRegQ[aluRd];
                dstData <= aluDataQ[aluRd];
            end
        end
    end

    always_comb begin
        pendingMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (aluVld[i]) begin
                pendingMask = pendingMask | (16'h0001 << aluRegQ[i]);
            end
            if (memVld[i]) begin
                pendingMask = pendingMask | (16'h0001 << memRegQ[i]);
            end
        end
        if (writeReg) begin
            pendingMask = pendingMask | (16'h0001 << dstReg);
        end
    end

    assign bus.WriteReg     = writeReg;
    assign bus.DstReg       = dstReg;
    assign bus.DstData      = dstData;
    assign bus.pending_mask = pendingMask;

endmodule
